// File: rtl/gate_tt_sequencer_pkg.sv
// Shared types and configuration limits for the gate truth-table sequencer.
package gate_seq_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_APPLY  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    APPLY  = ST_APPLY,
    SAMPLE = ST_SAMPLE,
    DONE   = ST_DONE
  } state_t;

  localparam int N_IN_MIN       = 32'sd1;
  localparam int N_IN_MAX       = 32'sd4;
  localparam int SETTLE_MIN     = 32'sd1;

  function automatic logic cfg_legal(input int n_in, input int settle);
    return (n_in >= N_IN_MIN) && (n_in <= N_IN_MAX) && (settle >= SETTLE_MIN);
  endfunction

endpackage

// File: rtl/gate_tt_sequencer_if.sv
// Host/gate-side signal bundle for the sequencer; master is the sequencer itself.
interface gate_tt_sequencer_if #(
  parameter int N_IN = 2
);
  localparam int V = 2 ** N_IN;

  logic            start;
  logic [V-1:0]    expected;
  logic [N_IN-1:0] dut_in;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [V-1:0]    fail_mask;

  modport master (
    input  start, expected, dut_out,
    output dut_in, busy, done, pass, fail_mask
  );

  modport slave (
    output start, expected, dut_out,
    input  dut_in, busy, done, pass, fail_mask
  );

endinterface

// File: rtl/gate_tt_sequencer_settle_cnt.sv
// Settle-time counter: cleared by load, counts while enabled, flags SETTLE_CYCLES-1.
module gate_seq_settle_cnt #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int CW = $clog2(SETTLE_CYCLES) + 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = {CW{1'b0}};
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CW'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/gate_tt_sequencer.sv
// Steps a combinational gate through every input vector and checks it against a
// supplied truth table. Define GATE_SEQ_FULL_SCAN_EN to scan all vectors instead
// of stopping at the first mismatch.
module gate_tt_sequencer
  import gate_seq_pkg::*;
#(
  parameter int N_IN          = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  gate_tt_sequencer_if.master bus
);
  localparam int   V      = 2 ** N_IN;
  // An out-of-range configuration leaves the sequencer inert rather than half-working.
  localparam logic CFG_OK = cfg_legal(N_IN, SETTLE_CYCLES);

  state_t          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [V-1:0]    exp_q, exp_d;
  logic [V-1:0]    mask_q, mask_d;
  logic            pass_q, pass_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic [N_IN-1:0] dut_in_q, dut_in_d;
  logic            tc_s, mismatch_s, abort_s, last_s;

  gate_seq_settle_cnt #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk    (clk),
    .rst    (rst),
    .load_i (state_q != APPLY),
    .en_i   (state_q == APPLY),
    .tc_o   (tc_s)
  );

  assign mismatch_s = (state_q == SAMPLE) && (bus.dut_out != exp_q[vec_q]);
  assign last_s     = &vec_q;
`ifdef GATE_SEQ_FULL_SCAN_EN
  assign abort_s    = 1'b0;
`else
  assign abort_s    = mismatch_s;
`endif

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    exp_d   = exp_q;
    mask_d  = mask_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: begin
        if (bus.start && CFG_OK) begin
          state_d = APPLY;
          exp_d   = bus.expected;
          vec_d   = {N_IN{1'b0}};
          mask_d  = {V{1'b0}};
          pass_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      APPLY: begin
        if (tc_s) begin
          state_d = SAMPLE;
        end else begin
          state_d = APPLY;
        end
      end
      SAMPLE: begin
        if (mismatch_s) begin
          mask_d[vec_q] = 1'b1;
        end else begin
          mask_d = mask_q;
        end
        if (last_s || abort_s) begin
          state_d = DONE;
          pass_d  = (mask_d == {V{1'b0}});
        end else begin
          state_d = APPLY;
          vec_d   = vec_q + N_IN'(1'b1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from next-state so they line up with the state they describe.
  always_comb begin
    busy_d   = (state_d == APPLY) || (state_d == SAMPLE);
    done_d   = (state_d == DONE);
    if (busy_d) begin
      dut_in_d = vec_d;
    end else begin
      dut_in_d = {N_IN{1'b0}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      vec_q    <= {N_IN{1'b0}};
      exp_q    <= {V{1'b0}};
      mask_q   <= {V{1'b0}};
      pass_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      dut_in_q <= {N_IN{1'b0}};
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      exp_q    <= exp_d;
      mask_q   <= mask_d;
      pass_q   <= pass_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      dut_in_q <= dut_in_d;
    end
  end

  assign bus.dut_in    = dut_in_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_mask = mask_q;

endmodule

// File: doc/gate_tt_sequencer.md
# gate_tt_sequencer

Self-test controller that sequences a single-output combinational gate (e.g. the mux-built AND gate) through its full truth table. On `start` it drives every input vector in order and waits a programmable settle time. It samples the gate output, compares it against a caller-supplied expected truth table, and reports pass/fail with a per-vector mismatch mask. It sits between a host or bench controller and one gate-under-test instance, replacing hand-written stimulus sequences.

## Interface
- `N_IN`, default 2: number of gate inputs; number of vectors `V = 2**N_IN`; legal range 1..4.
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling; must be ≥1.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request a scan; honoured only in IDLE.
- `expected`  in  V: truth table; bit i = expected gate output for input vector i; captured on accepted `start`.
- `dut_in`  out  N_IN: registered drive to gate inputs (bit 0 = LSB input, e.g. `b` for a 2-input gate, `a` = bit 1).
- `dut_out`  in  1: gate output, sampled in SAMPLE state.
- `busy`  out  1: high in APPLY and SAMPLE.
- `done`  out  1: one-cycle pulse at scan end.
- `pass`  out  1: 1 when no mismatches; valid from `done` until next accepted `start`.
- `fail_mask`  out  V: bit i set when vector i mismatched; same validity as `pass`.

## Operation
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE → APPLY on `start`:
  - `expected` latched, vector index `vec`=0, settle count=0, `fail_mask` cleared, `pass` cleared.
- APPLY: `dut_in`=`vec`; count increments each cycle; at count = SETTLE_CYCLES−1 → SAMPLE.
- SAMPLE: `dut_in` still = `vec`; mismatch if `dut_out` ≠ `expected[vec]`, which sets `fail_mask[vec]`.
  - If last vector (or abort condition, see Configuration) → DONE.
  - Otherwise `vec`+1, count=0 → APPLY.
- DONE: `done`=1 for exactly one cycle; `pass` = (final `fail_mask` == 0); → IDLE.
- `start` in APPLY, SAMPLE or DONE is ignored, not queued.
- `dut_in` returns to 0 in IDLE and DONE.
- `vec` never wraps; after vector V−1 the scan always ends.
- Reset (any time, incl. mid-scan): state=IDLE, `dut_in`=0, `busy`=0, `done`=0, `pass`=0, `fail_mask`=0, `expected` latch=0.

## Timing
- Cycle 0: `start` sampled high in IDLE. Cycle 1: first APPLY cycle.
- Each vector costs SETTLE_CYCLES+1 cycles.
- Full scan: `done` high in cycle 1 + V·(SETTLE_CYCLES+1). Defaults give cycle 13.
- Earliest next accepted `start` is the cycle after `done`.
- `dut_out` must settle within SETTLE_CYCLES−1 cycles plus one clock period of `dut_in` changing.
- All outputs registered; no combinational path from `dut_out` or `start` to any output.

## Configuration
- `GATE_SEQ_FULL_SCAN_EN` defined:
  - All V vectors are always applied.
  - `fail_mask` accumulates every mismatch.
  - Latency is fixed.
- `GATE_SEQ_FULL_SCAN_EN` not defined:
  - The scan aborts in the SAMPLE cycle of the first mismatch and goes → DONE.
  - `fail_mask` has at most one bit set.
  - A passing scan has the same latency as full scan.

## Structure
- Package `gate_seq_pkg`:
  - state encoding localparams (IDLE=2'd0, APPLY=2'd1, SAMPLE=2'd2, DONE=2'd3);
  - the `N_IN`/`SETTLE_CYCLES` range-check constants.
- Sub-module `gate_seq_settle_cnt`: settle counter with load/enable and terminal-count output, width `$clog2(SETTLE_CYCLES)+1`.
- FSM and vector/mask registers live in the top module.

## Test plan
- AND DUT, `expected`=4'b1000, defaults, pulse `start` → `dut_in` steps 0,1,2,3; `done` in cycle 13; `pass`=1; `fail_mask`=4'b0000.
- AND DUT, `expected`=4'b1110 (OR table):
  - with macro → `done` cycle 13, `pass`=0, `fail_mask`=4'b0110;
  - without macro → `done` cycle 7, `fail_mask`=4'b0010.
- `dut_out` stuck at 1, `expected`=4'b1000, with macro → `pass`=0, `fail_mask`=4'b0111.
- `SETTLE_CYCLES`=1, AND DUT, `expected`=4'b1000 → `done` in cycle 9, `pass`=1.
- `start` re-pulsed in cycles 3 and 13 → both ignored; one `done`; a `start` in cycle 14 is accepted.
- Assert `rst` in cycle 5 of a scan → same cycle `busy`=0 and `dut_in`=0; all outputs 0; next `start` runs a clean scan with `pass`=1.
